// File: rtl/nabp_angle_sequencer_if.sv
// ----------------------------------------------------------------------------
// nabp_angle_sequencer_if
//   Angle channel between the angle sequencer and the mode-control logic and
//   datapath.
//   master (sequencer) drives : angle, angle_valid, sector_first, last_angle
//   master (sequencer) samples: angle_ready, proc_done
//   slave  (consumer)  is the mirror image.
// ----------------------------------------------------------------------------
interface nabp_angle_sequencer_if #(
  parameter int ANGLE_WIDTH = 9
);
  logic [ANGLE_WIDTH-1:0] angle;
  logic                   angle_valid;
  logic                   angle_ready;
  logic                   sector_first;
  logic                   last_angle;
  logic                   proc_done;

  modport master (
    output angle, angle_valid, sector_first, last_angle,
    input  angle_ready, proc_done
  );

  modport slave (
    input  angle, angle_valid, sector_first, last_angle,
    output angle_ready, proc_done
  );
endinterface

// File: rtl/nabp_angle_sequencer.sv
// ----------------------------------------------------------------------------
// nabp_angle_sequencer
//   Walks projection angles 0, ANGLE_STEP, ... below ANGLE_END, offering each
//   one on a valid/ready channel and holding it until the datapath reports
//   proc_done. Flags the first angle of each sector (a/b/c/d split at
//   ANGLE_45/90/135) and the final angle of the sweep.
// Ports
//   clk, reset_n : clock (rising edge), asynchronous active-low reset
//   start        : pulse, begins a sweep from IDLE
//   abort        : pulse, drops any sweep in progress back to IDLE
//   busy         : high whenever not IDLE
//   sweep_done   : one-cycle pulse after the final angle is processed
//   ang          : angle channel (angle/valid/ready, sector_first,
//                  last_angle, proc_done)
// All outputs are registered.
// ----------------------------------------------------------------------------
module nabp_angle_sequencer #(
  parameter int ANGLE_WIDTH = 9,
  parameter int ANGLE_STEP  = 1,
  parameter int ANGLE_END   = 180,
  parameter int ANGLE_45    = 45,
  parameter int ANGLE_90    = 90,
  parameter int ANGLE_135   = 135
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         start,
  input  logic                         abort,
  output logic                         busy,
  output logic                         sweep_done,
  nabp_angle_sequencer_if.master       ang
);

  typedef enum logic [1:0] {S_IDLE, S_OFFER, S_WAIT, S_FINISH} state_t;

  localparam logic [ANGLE_WIDTH-1:0] STEP_N = ANGLE_WIDTH'(ANGLE_STEP);
  localparam logic [ANGLE_WIDTH:0]   STEP_W = (ANGLE_WIDTH+1)'(ANGLE_STEP);
  localparam logic [ANGLE_WIDTH:0]   END_W  = (ANGLE_WIDTH+1)'(ANGLE_END);
  localparam logic [ANGLE_WIDTH-1:0] A45    = ANGLE_WIDTH'(ANGLE_45);
  localparam logic [ANGLE_WIDTH-1:0] A90    = ANGLE_WIDTH'(ANGLE_90);
  localparam logic [ANGLE_WIDTH-1:0] A135   = ANGLE_WIDTH'(ANGLE_135);

  function automatic logic [1:0] sector_of(input logic [ANGLE_WIDTH-1:0] x);
    if (x < A45)       return 2'd0;
    else if (x < A90)  return 2'd1;
    else if (x < A135) return 2'd2;
    else               return 2'd3;
  endfunction

  // One extra bit keeps angle+step from wrapping near the top of the range,
  // so a non-dividing step still terminates on the largest angle below END.
  function automatic logic is_last(input logic [ANGLE_WIDTH-1:0] x);
    logic [ANGLE_WIDTH:0] sum;
    sum = {1'b0, x} + STEP_W;
    return (sum >= END_W);
  endfunction

  state_t                 state_q, state_d;
  logic [ANGLE_WIDTH-1:0] angle_q, angle_d;
  logic                   valid_q, valid_d;
  logic                   sf_q, sf_d;
  logic                   last_q, last_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic [ANGLE_WIDTH-1:0] next_angle;

  // Only used when the current angle is not the last, so it always fits.
  assign next_angle = angle_q + STEP_N;

  always_comb begin
    state_d = state_q;
    angle_d = angle_q;
    valid_d = valid_q;
    sf_d    = sf_q;
    last_d  = last_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_OFFER;
          angle_d = '0;
          valid_d = 1'b1;
          sf_d    = 1'b1;
          last_d  = is_last('0);
          busy_d  = 1'b1;
        end
      end
      S_OFFER: begin
        if (valid_q && ang.angle_ready) begin
          state_d = S_WAIT;
          valid_d = 1'b0;
        end
      end
      S_WAIT: begin
        if (ang.proc_done) begin
          if (last_q) begin
            state_d = S_FINISH;
            done_d  = 1'b1;
          end else begin
            state_d = S_OFFER;
            angle_d = next_angle;
            valid_d = 1'b1;
            sf_d    = (sector_of(next_angle) != sector_of(angle_q));
            last_d  = is_last(next_angle);
          end
        end
      end
      S_FINISH: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        valid_d = 1'b0;
      end
    endcase

    // abort overrides everything else, but leaves an idle sequencer untouched
    // so the held final angle of a completed sweep survives a stray abort.
    if (abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      angle_d = '0;
      valid_d = 1'b0;
      sf_d    = 1'b0;
      last_d  = 1'b0;
      busy_d  = 1'b0;
      done_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      angle_q <= '0;
      valid_q <= 1'b0;
      sf_q    <= 1'b0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      angle_q <= angle_d;
      valid_q <= valid_d;
      sf_q    <= sf_d;
      last_q  <= last_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign ang.angle        = angle_q;
  assign ang.angle_valid  = valid_q;
  assign ang.sector_first = sf_q;
  assign ang.last_angle   = last_q;
  assign busy             = busy_q;
  assign sweep_done       = done_q;

endmodule
